// File: rtl/agc_pkg.sv
// rtl/agc_pkg.sv - register map, FSM states and field positions for the AGC readout controller
package agc_pkg;

  localparam logic [31:0] REG_CLR  = 32'h0000_0010;
  localparam logic [31:0] REG_LOST = 32'h0000_0014;
  localparam logic [31:0] REG_OCC  = 32'h0000_0018;
  localparam logic [31:0] REG_HDR  = 32'h0000_0020;
  localparam logic [31:0] REG_T0   = 32'h0000_0024;
  localparam logic [31:0] REG_T1   = 32'h0000_0028;

  localparam int HDR_VALID   = 31;
  localparam int HDR_TYPE    = 30;
  localparam int HDR_AMP_MSB = 29;
  localparam int HDR_AMP_LSB = 16;

  localparam int EV_TYPE    = 62;
  localparam int EV_AMP_MSB = 61;
  localparam int EV_AMP_LSB = 48;
  localparam int EV_T1_MSB  = 47;
  localparam int EV_T1_LSB  = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_POLL, S_RD_T0, S_RD_T1, S_GAP, S_STATS
  } state_t;

  function automatic logic [63:0] pack_event(input logic typ, input logic [13:0] amp,
                                             input logic [15:0] t1, input logic [31:0] t0);
    logic [63:0] w;
    w = '0;
    w[EV_TYPE] = typ;
    w[EV_AMP_MSB:EV_AMP_LSB] = amp;
    w[EV_T1_MSB:EV_T1_LSB] = t1;
    w[31:0] = t0;
    return w;
  endfunction

endpackage

// File: rtl/agc_bus_txn.sv
// rtl/agc_bus_txn.sv - single-transaction bus master: one-cycle strobe, wait for ack or timeout
module agc_bus_txn #(
  parameter int BUS_TMO = 15
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        start_i,
  input  logic        write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  output logic        m_wen_o,
  output logic        m_ren_o,
  input  logic        m_ack_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam logic [15:0] TMO_LAST = 16'(BUS_TMO - 1);

  logic [15:0] wait_q;

  assign done_o = busy_o & m_ack_i;
  assign err_o  = busy_o & ~m_ack_i & (wait_q == TMO_LAST);

  // Strobes default low every cycle so a read of the popping register can never be held.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      m_addr_o  <= '0;
      m_wdata_o <= '0;
      m_wen_o   <= 1'b0;
      m_ren_o   <= 1'b0;
      busy_o    <= 1'b0;
      wait_q    <= '0;
    end else begin
      m_wen_o <= 1'b0;
      m_ren_o <= 1'b0;
      if (start_i) begin
        busy_o    <= 1'b1;
        wait_q    <= '0;
        m_addr_o  <= addr_i;
        m_wdata_o <= write_i ? wdata_i : '0;
        m_wen_o   <= write_i;
        m_ren_o   <= ~write_i;
      end else if (done_o || err_o) begin
        busy_o <= 1'b0;
      end else if (busy_o) begin
        wait_q <= wait_q + 16'd1;
      end
    end
  end

endmodule

// File: rtl/agc_readout_ctrl.sv
// rtl/agc_readout_ctrl.sv - run control and event readout sequencer; AGC_RDCTRL_STATS_EN adds end-of-run stats reads
module agc_readout_ctrl
  import agc_pkg::*;
#(
  parameter int BUS_TMO  = 15,
  parameter int POP_GAP  = 8,
  parameter int POLL_GAP = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        run_start_i,
  input  logic        run_stop_i,
  input  logic [31:0] run_len_i,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  output logic        m_wen_o,
  output logic        m_ren_o,
  input  logic [31:0] m_rdata_i,
  input  logic        m_ack_i,
  output logic [63:0] ev_data_o,
  output logic        ev_valid_o,
  input  logic        ev_ready_i,
  output logic        run_active_o,
  output logic [31:0] ev_count_o,
  output logic        bus_err_o,
  output logic [31:0] lost_o,
  output logic [15:0] fifo_hw_o
);

  state_t      state_q, state_d;
  logic [7:0]  gap_q;
  logic        stop_q, stop_now, go_end;
  logic [31:0] len_q, tmr_q, t0_q;
  logic        hdr_type_q;
  logic [13:0] hdr_amp_q;
  logic        iss, iss_wr;
  logic [31:0] iss_addr;
  logic        txn_busy, txn_done, txn_err;
`ifdef AGC_RDCTRL_STATS_EN
  logic        stat_sel_q;
`endif

  agc_bus_txn #(.BUS_TMO(BUS_TMO)) u_txn (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .start_i   (iss),
    .write_i   (iss_wr),
    .addr_i    (iss_addr),
    .wdata_i   (32'h1),
    .m_addr_o  (m_addr_o),
    .m_wdata_o (m_wdata_o),
    .m_wen_o   (m_wen_o),
    .m_ren_o   (m_ren_o),
    .m_ack_i   (m_ack_i),
    .busy_o    (txn_busy),
    .done_o    (txn_done),
    .err_o     (txn_err)
  );

  assign run_active_o = (state_q != S_IDLE);
  assign stop_now     = stop_q | ((len_q != '0) && (tmr_q == len_q));

  // Bus strobes are issued on the transition decision so each read costs two cycles.
  always_comb begin
    state_d  = state_q;
    iss      = 1'b0;
    iss_wr   = 1'b0;
    iss_addr = REG_HDR;
    go_end   = 1'b0;
    case (state_q)
      S_IDLE: if (run_start_i) begin
        state_d = S_CLR; iss = 1'b1; iss_wr = 1'b1; iss_addr = REG_CLR;
      end
      S_CLR: if (txn_done) state_d = S_POLL;
      S_POLL: begin
        if (txn_done) begin
          if (m_rdata_i[HDR_VALID]) begin
            state_d = S_RD_T0; iss = 1'b1; iss_addr = REG_T0;
          end
        end else if (!txn_busy && gap_q == '0) begin
          if (stop_now) go_end = 1'b1;
          else if (!ev_valid_o) iss = 1'b1;
        end
      end
      S_RD_T0: if (txn_done) begin
        state_d = S_RD_T1; iss = 1'b1; iss_addr = REG_T1;
      end
      S_RD_T1: if (txn_done) state_d = S_GAP;
      S_GAP: if (gap_q == '0) begin
        if (stop_now) go_end = 1'b1;
        else begin
          state_d = S_POLL; iss = ~ev_valid_o;
        end
      end
`ifdef AGC_RDCTRL_STATS_EN
      S_STATS: if (txn_done) begin
        if (!stat_sel_q) begin
          iss = 1'b1; iss_addr = REG_OCC;
        end else begin
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (go_end) begin
`ifdef AGC_RDCTRL_STATS_EN
      state_d = S_STATS; iss = 1'b1; iss_addr = REG_LOST;
`else
      state_d = S_IDLE;
`endif
    end
    if (txn_err) begin
      state_d = S_IDLE; iss = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      gap_q      <= '0;
      stop_q     <= 1'b0;
      len_q      <= '0;
      tmr_q      <= '0;
      t0_q       <= '0;
      hdr_type_q <= 1'b0;
      hdr_amp_q  <= '0;
      ev_valid_o <= 1'b0;
      ev_data_o  <= '0;
      ev_count_o <= '0;
      bus_err_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && run_start_i) begin
        stop_q     <= 1'b0;
        len_q      <= run_len_i;
        tmr_q      <= '0;
        ev_count_o <= '0;
        bus_err_o  <= 1'b0;
      end else begin
        if (run_stop_i && state_q != S_IDLE) stop_q <= 1'b1;
        if (state_q != S_IDLE && (len_q == '0 || tmr_q != len_q)) tmr_q <= tmr_q + 32'd1;
        if (ev_valid_o && ev_ready_i) ev_count_o <= ev_count_o + 32'd1;
        if (txn_err) bus_err_o <= 1'b1;
      end
      // Gap counters hold N-1 so exactly N idle bus cycles separate ack and next strobe.
      if (state_q == S_POLL && txn_done && !m_rdata_i[HDR_VALID]) gap_q <= 8'(POLL_GAP - 1);
      else if (state_q == S_RD_T1 && txn_done) gap_q <= 8'(POP_GAP - 1);
      else if (gap_q != '0) gap_q <= gap_q - 8'd1;
      if (state_q == S_POLL && txn_done) begin
        hdr_type_q <= m_rdata_i[HDR_TYPE];
        hdr_amp_q  <= m_rdata_i[HDR_AMP_MSB:HDR_AMP_LSB];
      end
      if (state_q == S_RD_T0 && txn_done) t0_q <= m_rdata_i;
      if (state_q == S_RD_T1 && txn_done) begin
        ev_data_o  <= pack_event(hdr_type_q, hdr_amp_q, m_rdata_i[15:0], t0_q);
        ev_valid_o <= 1'b1;
      end else if (ev_valid_o && ev_ready_i) begin
        ev_valid_o <= 1'b0;
      end
    end
  end

`ifdef AGC_RDCTRL_STATS_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stat_sel_q <= 1'b0;
      lost_o     <= '0;
      fifo_hw_o  <= '0;
    end else if (state_q == S_STATS && txn_done) begin
      if (!stat_sel_q) begin
        lost_o     <= m_rdata_i;
        stat_sel_q <= 1'b1;
      end else begin
        fifo_hw_o  <= m_rdata_i[31:16];
        stat_sel_q <= 1'b0;
      end
    end
  end
`else
  assign lost_o    = '0;
  assign fifo_hw_o = '0;
`endif

endmodule
